// File: rtl/memory_page_reader_if.sv
// Memory read port plus the output word stream of memory_page_reader.
// The master side is the reader; the slave side is the memory and stream consumer.
interface memory_page_reader_if #(
    parameter int RAM_WIDTH = 18,
    parameter int AW        = 10
);
    logic [AW-1:0]        addrb;
    logic                 enb;
    logic                 regceb;
    logic [RAM_WIDTH-1:0] doutb;
    logic [RAM_WIDTH-1:0] out_data;
    logic [2:0]           out_page;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output addrb, enb, regceb,
        input  doutb,
        output out_data, out_page, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  addrb, enb, regceb,
        output doutb,
        input  out_data, out_page, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/memory_page_reader.sv
// Paged BRAM readout sequencer: walks active pages, absorbs read latency, streams words.
// Optional MEMORY_READER_ABORT_EN adds an abort input that flushes and finishes early.
module memory_page_reader #(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int PAGE_SIZE    = 128,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  page_mask,
    input  logic [63:0] nent_i,
`ifdef MEMORY_READER_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        done,
    memory_page_reader_if.master bus
);
    localparam int AW = $clog2(RAM_DEPTH);
    localparam int FD = READ_LATENCY + 2;
    localparam int IW = $clog2(PAGE_SIZE);
    localparam int CW = IW + 1;
    localparam int PW = $clog2(FD);
    localparam int NW = $clog2(FD + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
    typedef struct packed { logic [2:0] page; logic last; } tag_t;
    typedef struct packed { logic [RAM_WIDTH-1:0] data; tag_t tag; } word_t;

    state_t                   state, state_nx;
    logic [7:0]               pend;
    logic [7:0][CW-1:0]       cnt;
    logic [IW-1:0]            idx;
    logic [2:0]               cur_page;
    logic [CW-1:0]            cur_cnt;
    logic                     idx_last, issue, flush, abort_q;
    logic [7:0]               start_act;
    logic [READ_LATENCY:1]    vld_pipe;
    tag_t [READ_LATENCY:1]    tag_pipe;
    word_t                    fifo_mem [FD];
    word_t                    head;
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [NW-1:0]            fifo_cnt;
    logic                     fifo_wr, fifo_rd, out_valid;
    logic                     credit_ok, drain_ok;
    int                       in_use;
    logic [AW-1:0]            addr_w;
    logic                     enb_w;

`ifdef MEMORY_READER_ABORT_EN
    assign abort_q = abort;
`else
    assign abort_q = 1'b0;
`endif
    assign flush = abort_q && (state != IDLE);

    function automatic logic [CW-1:0] clamp(input logic [7:0] n);
        if (int'(n) > PAGE_SIZE) return CW'(PAGE_SIZE);
        return CW'(n);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == FD - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        start_act = '0;
        for (int p = 0; p < 8; p++)
            start_act[p] = page_mask[p] && (nent_i[8*p +: 8] != 8'd0);
    end

    // Current page is the lowest page still pending.
    always_comb begin
        cur_page = 3'd0;
        for (int p = 7; p >= 0; p--)
            if (pend[p]) cur_page = 3'(p);
    end

    assign cur_cnt  = cnt[cur_page];
    assign idx_last = ({1'b0, idx} == cur_cnt - CW'(1));

    // Credit counts every word that has been issued and not yet popped.
    always_comb begin
        in_use = int'(fifo_cnt);
        for (int k = 1; k <= READ_LATENCY; k++)
            in_use = in_use + int'(vld_pipe[k]);
    end
    assign credit_ok = in_use < FD;
    assign issue     = (state == ISSUE) && credit_ok && !abort_q;
    assign fifo_wr   = vld_pipe[READ_LATENCY];
    assign out_valid = (fifo_cnt != '0);
    assign fifo_rd   = out_valid && bus.out_ready;
    assign drain_ok  = (vld_pipe == '0) &&
                       ((fifo_cnt == '0) || ((fifo_cnt == NW'(1)) && fifo_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // An empty readout still spends one busy cycle in DRAIN so done lands at cycle 2.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:   if (start) state_nx = (|start_act) ? ISSUE : DRAIN;
            ISSUE:  if (abort_q) state_nx = FINISH;
                    else if (issue && idx_last &&
                             ((pend & ~(8'd1 << cur_page)) == 8'd0)) state_nx = DRAIN;
            DRAIN:  if (abort_q || drain_ok) state_nx = FINISH;
            FINISH: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        done   = (state == FINISH);
        enb_w  = issue;
        addr_w = issue ? AW'({cur_page, idx}) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            cnt  <= '0;
            idx  <= '0;
        end else if (state == IDLE && start) begin
            pend <= start_act;
            idx  <= '0;
            for (int p = 0; p < 8; p++) cnt[p] <= clamp(nent_i[8*p +: 8]);
        end else if (issue) begin
            if (idx_last) begin
                pend[cur_page] <= 1'b0;
                idx            <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else begin
            vld_pipe[1] <= issue && !flush;
            tag_pipe[1] <= '{page: cur_page, last: idx_last};
            for (int k = 2; k <= READ_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1] && !flush;
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= '{data: bus.doutb, tag: tag_pipe[READ_LATENCY]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (fifo_rd) rd_ptr <= ptr_inc(rd_ptr);
            fifo_cnt <= fifo_cnt + NW'(fifo_wr) - NW'(fifo_rd);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_wr && !fifo_rd && int'(fifo_cnt) == FD));

    assign head          = fifo_mem[rd_ptr];
    assign bus.addrb     = addr_w;
    assign bus.enb       = enb_w;
    assign bus.regceb    = 1'b1;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? head.data     : '0;
    assign bus.out_page  = out_valid ? head.tag.page : 3'd0;
    assign bus.out_last  = out_valid && head.tag.last;
endmodule

// File: tb/tb_memory_page_reader.sv
// Bench for memory_page_reader: vector table, random readouts against a page-walk model,
// plus reset, start-while-busy and abort sequences.
module tb_memory_page_reader;
    localparam int RW = 18;
    localparam int AW = 10;
    localparam int PS = 128;
    localparam int RL = 2;
    localparam int FD = RL + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  page_mask = '0;
    logic [63:0] nent_i = '0;
`ifdef MEMORY_READER_ABORT_EN
    logic        abort = 1'b0;
`endif
    logic        busy, done;
    int          checks = 0;
    int          errors = 0;
    logic [RW-1:0] r1;

    memory_page_reader_if #(.RAM_WIDTH(RW), .AW(AW)) bus();

    memory_page_reader #(.RAM_WIDTH(RW), .RAM_DEPTH(1024), .PAGE_SIZE(PS), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .page_mask(page_mask), .nent_i(nent_i),
`ifdef MEMORY_READER_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [RW-1:0] mem_word(input int a);
        return RW'(a * 37 + 5);
    endfunction

    // Two-stage BRAM with output register
    always_ff @(posedge clk) begin
        if (bus.enb)    r1 <= mem_word(int'(bus.addrb));
        if (bus.regceb) bus.doutb <= r1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, " busy"}, busy, 0);
        check({name, " enb"}, bus.enb, 0);
        check({name, " addrb"}, bus.addrb, 0);
        check({name, " out_valid"}, bus.out_valid, 0);
        check({name, " out_last"}, bus.out_last, 0);
        check({name, " out_data"}, bus.out_data, 0);
        check({name, " out_page"}, bus.out_page, 0);
        check({name, " done"}, done, 0);
        check({name, " regceb"}, bus.regceb, 1);
    endtask

    task automatic run_readout(input logic [7:0] mask, input logic [63:0] nent, input int rmode,
                               input int exp_n, input int exp_done);
        int q_addr[$];
        logic [2:0] q_page[$];
        logic q_last[$];
        int issued = 0, popped = 0, done_c = -1, last_pop_c = -1;
        logic stall = 1'b0;
        logic [21:0] held = '0;
        for (int p = 0; p < 8; p++) begin
            if (mask[p]) begin
                int n;
                n = int'(nent[8*p +: 8]);
                if (n > PS) n = PS;
                for (int i = 0; i < n; i++) begin
                    q_addr.push_back(p * PS + i);
                    q_page.push_back(3'(p));
                    q_last.push_back(i == n - 1);
                end
            end
        end
        for (int c = 0; c < 3000 && done_c < 0; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (c == 2);
            page_mask = (c == 0) ? mask : 8'hFF;
            if (c == 0) nent_i = nent;
            else if (c == 3) nent_i = {$urandom, $urandom};
            bus.out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("busy", busy, c >= 1);
            if (bus.enb) begin
                check("read_in_range", issued < q_addr.size(), 1);
                if (issued < q_addr.size()) check("addrb", bus.addrb, q_addr[issued]);
                if (rmode == 0) check("issue_cycle", c, issued + 1);
                issued++;
                check("outstanding_le_fifo_depth", (issued - popped) <= FD, 1);
            end
            if (stall) begin
                check("hold_valid", bus.out_valid, 1);
                check("hold_fields", {bus.out_data, bus.out_page, bus.out_last}, held);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("word_in_range", popped < q_addr.size(), 1);
                if (popped < q_addr.size()) begin
                    check("out_data", bus.out_data, mem_word(q_addr[popped]));
                    check("out_page", bus.out_page, q_page[popped]);
                    check("out_last", bus.out_last, q_last[popped]);
                end
                if (rmode == 0) check("word_cycle", c, popped + 2 + RL);
                popped++;
                last_pop_c = c;
            end
            stall = bus.out_valid && !bus.out_ready;
            held  = {bus.out_data, bus.out_page, bus.out_last};
            if (done) done_c = c;
        end
        start = 1'b0;
        check("done_seen", done_c >= 0, 1);
        if (exp_done >= 0) check("done_cycle", done_c, exp_done);
        check("words_vs_model", popped, q_addr.size());
        if (exp_n >= 0) check("word_count", popped, exp_n);
        if (popped == 0) check("empty_done_cycle", done_c, 2);
        else             check("done_after_last_word", done_c, last_pop_c + 1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("post_busy", busy, 0);
            check("post_enb", bus.enb, 0);
            check("post_valid", bus.out_valid, 0);
            check("post_done", done, 0);
        end
    endtask

    typedef struct {
        logic [7:0]  mask;
        logic [63:0] nent;
        int          rmode;
        int          exp_n;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hFF, 64'h0000_0000_0001_0003, 0, 4, 8};
        vecs[1] = '{8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 2};
        vecs[2] = '{8'hFF, 64'h0000_0000_0000_0000, 0, 0, 2};
        vecs[3] = '{8'h02, 64'h0000_0000_0000_0A00, 1, 10, -1};
        vecs[4] = '{8'h80, 64'hC800_0000_0000_0000, 0, 128, 132};
        vecs[5] = '{8'h5A, 64'h0102_0304_0506_0708, 1, 18, -1};
        vecs[6] = '{8'hFF, 64'h0101_0101_0101_0101, 0, 8, 12};
        vecs[7] = '{8'h81, 64'hFF00_0000_0000_0080, 1, 256, -1};

        bus.out_ready = 1'b1;
        #2;
        check_idle("reset");
        #10 rst_n = 1'b1;

        for (int v = 0; v < 8; v++)
            run_readout(vecs[v].mask, vecs[v].nent, vecs[v].rmode, vecs[v].exp_n, vecs[v].exp_done);

        for (int r = 0; r < 6; r++) begin
            logic [63:0] nn;
            for (int p = 0; p < 8; p++)
                nn[8*p +: 8] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            run_readout(8'($urandom), nn, 1, -1, -1);
        end

        // Reset asserted mid-stream
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            page_mask = 8'h01;
            nent_i = 64'd20;
            bus.out_ready = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("after_reset_busy", busy, 0);
            check("after_reset_valid", bus.out_valid, 0);
        end
        run_readout(8'h04, 64'h0000_0000_0005_0000, 0, 5, 9);

`ifdef MEMORY_READER_ABORT_EN
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            page_mask = 8'h02;
            nent_i = 64'h0000_0000_0000_0A00;
            abort = (c == 3);
            bus.out_ready = 1'b1;
            @(negedge clk);
            if (c == 3) check("abort_no_early_done", done, 0);
            if (c == 4) begin
                check("abort_done", done, 1);
                check("abort_valid_drop", bus.out_valid, 0);
            end
            if (c >= 5) begin
                check("abort_after_valid", bus.out_valid, 0);
                check("abort_after_busy", busy, 0);
                check("abort_after_enb", bus.enb, 0);
            end
        end
        abort = 1'b0;
        run_readout(8'h02, 64'h0000_0000_0000_0A00, 0, 10, 14);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
